// File: rtl/clkrecv.sv
// Receive-side conditioner for an externally driven serial clock (SPI SCK / I2C SCL).
// Synchronizes and deglitches sclk_i, emits edge strobes, measures half-periods, and tracks bursts.
module clkrecv #(
   parameter int unsigned SYNC_STAGES  = 2,
   parameter int unsigned FILTER       = 2,
   parameter int unsigned IDLE_HIGH    = 1,
   parameter int unsigned MIN_HALF     = 4,
   parameter int unsigned IDLE_TIMEOUT = 16,
   parameter int unsigned CNT_WIDTH    = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 sclk_i,
   input  logic                 clear_i,
   output logic                 rise_o,
   output logic                 fall_o,
   output logic                 active_o,
   output logic [CNT_WIDTH-1:0] half_period_o,
   output logic                 too_fast_o,
   output logic                 stall_o
);

   localparam int unsigned FLT_W    = (FILTER > 1) ? $clog2(FILTER) : 1;
   localparam logic        IDLE_LVL = (IDLE_HIGH != 0);

   generate
      if (SYNC_STAGES < 2 || FILTER < 1 || IDLE_HIGH > 1 || MIN_HALF < 1 ||
          CNT_WIDTH < 1 || CNT_WIDTH > 32 || IDLE_TIMEOUT <= MIN_HALF ||
          64'(IDLE_TIMEOUT) >= ((64'd1 << CNT_WIDTH) - 64'd1)) begin : g_param_err
         $error("clkrecv: illegal parameter set");
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACTIVE  = 2'd1,
      ST_STALLED = 2'd2
   } state_e;

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_filt;
   logic                   r_filt_d;
   logic [FLT_W-1:0]       r_flt_cnt;
   logic [CNT_WIDTH-1:0]   r_hp_cnt;
   state_e                 r_state;
   state_e                 w_state_nxt;

   logic w_synced;
   logic w_rise;
   logic w_fall;
   logic w_strobe;
   logic w_lead;
   logic w_back;
   logic w_active_nxt;
   logic w_meas;
   logic w_set_fast;
   logic w_set_stall;

   // Metastability synchronizer, preset to the idle level
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_sync <= {SYNC_STAGES{IDLE_LVL}};
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], sclk_i};
      end
   end

   assign w_synced = r_sync[SYNC_STAGES-1];

   // Level filter: a new level must persist FILTER cycles before it is accepted
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_filt    <= IDLE_LVL;
         r_filt_d  <= IDLE_LVL;
         r_flt_cnt <= '0;
      end else begin
         r_filt_d <= r_filt;
         if (w_synced != r_filt) begin
            if (r_flt_cnt == FLT_W'(FILTER - 1)) begin
               r_filt    <= w_synced;
               r_flt_cnt <= '0;
            end else begin
               r_flt_cnt <= r_flt_cnt + FLT_W'(1);
            end
         end else begin
            r_flt_cnt <= '0;
         end
      end
   end

   assign w_rise   = r_filt & ~r_filt_d;
   assign w_fall   = ~r_filt & r_filt_d;
   assign w_strobe = w_rise | w_fall;
   assign w_lead   = IDLE_LVL ? w_fall : w_rise;
   assign w_back   = IDLE_LVL ? w_rise : w_fall;

   // Edge strobes and half-period counter; the counter restarts at 1 on each strobe
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rise_o   <= 1'b0;
         fall_o   <= 1'b0;
         r_hp_cnt <= '0;
      end else begin
         rise_o <= w_rise;
         fall_o <= w_fall;
         if (w_strobe) begin
            r_hp_cnt <= CNT_WIDTH'(1);
         end else if (r_hp_cnt != '1) begin
            r_hp_cnt <= r_hp_cnt + CNT_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // A strobe coinciding with the timeout keeps the burst alive
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_lead) w_state_nxt = ST_ACTIVE;
         end
         ST_ACTIVE: begin
            if (!w_strobe && (r_hp_cnt == CNT_WIDTH'(IDLE_TIMEOUT))) begin
               w_state_nxt = (r_filt == IDLE_LVL) ? ST_IDLE : ST_STALLED;
            end
         end
         ST_STALLED: begin
            if (w_back) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      w_meas      = 1'b0;
      w_set_fast  = 1'b0;
      w_set_stall = 1'b0;
      if (r_state == ST_ACTIVE) begin
         w_meas      = w_strobe;
         w_set_fast  = w_strobe && (r_hp_cnt < CNT_WIDTH'(MIN_HALF));
         w_set_stall = (w_state_nxt == ST_STALLED);
      end
      w_active_nxt = (w_state_nxt == ST_ACTIVE);
   end

   // Registered status; a flag set beats a simultaneous clear
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         active_o      <= 1'b0;
         half_period_o <= '0;
         too_fast_o    <= 1'b0;
         stall_o       <= 1'b0;
      end else begin
         active_o <= w_active_nxt;
         if (w_meas) half_period_o <= r_hp_cnt;
         too_fast_o <= w_set_fast  | (too_fast_o & ~clear_i);
         stall_o    <= w_set_stall | (stall_o & ~clear_i);
      end
   end

endmodule

// File: tb/tb_clkrecv.sv
// Directed bench for clkrecv at default parameters: strobes, filtering, timeout, stall, flags, reset.
module tb_clkrecv;

   logic       clk_i;
   logic       rst_ni;
   logic       sclk_i;
   logic       clear_i;
   logic       rise_o;
   logic       fall_o;
   logic       active_o;
   logic [7:0] half_period_o;
   logic       too_fast_o;
   logic       stall_o;

   int n_checks = 0;
   int n_errors = 0;

   clkrecv u_dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .sclk_i        (sclk_i),
      .clear_i       (clear_i),
      .rise_o        (rise_o),
      .fall_o        (fall_o),
      .active_o      (active_o),
      .half_period_o (half_period_o),
      .too_fast_o    (too_fast_o),
      .stall_o       (stall_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic check_byte(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check_bit({tag, "_rise"}, rise_o, 1'b0);
      check_bit({tag, "_fall"}, fall_o, 1'b0);
      check_bit({tag, "_active"}, active_o, 1'b0);
      check_byte({tag, "_half"}, half_period_o, 8'd0);
      check_bit({tag, "_too_fast"}, too_fast_o, 1'b0);
      check_bit({tag, "_stall"}, stall_o, 1'b0);
   endtask

   initial begin
      rst_ni  = 1'b0;
      sclk_i  = 1'b1;
      clear_i = 1'b0;
      #1;
      check_all_zero("t1_reset");
      step();
      step();
      rst_ni = 1'b1;

      // Idle-high line after reset: nothing happens
      for (int j = 0; j < 40; j++) begin
         step();
         check_bit("t1_rise", rise_o, 1'b0);
         check_bit("t1_fall", fall_o, 1'b0);
         check_bit("t1_active", active_o, 1'b0);
      end
      check_byte("t1_half", half_period_o, 8'd0);
      check_bit("t1_too_fast", too_fast_o, 1'b0);
      check_bit("t1_stall", stall_o, 1'b0);

      // DIV=8 clock, 5 periods, then idle high
      for (int j = 0; j < 60; j++) begin
         sclk_i = (j < 40) ? ((j % 8) >= 4) : 1'b1;
         step();
         check_bit("t2_fall", fall_o, (j >= 4 && j < 44 && ((j - 4) % 8) == 0));
         check_bit("t2_rise", rise_o, (j >= 4 && j < 44 && ((j - 4) % 8) == 4));
         check_bit("t2_active", active_o, (j >= 4 && j < 56));
         if (j == 6)  check_byte("t2_half_pre", half_period_o, 8'd0);
         if (j == 8)  check_byte("t2_half_first", half_period_o, 8'd4);
         if (j == 40) check_byte("t2_half_last", half_period_o, 8'd4);
      end
      check_bit("t2_too_fast", too_fast_o, 1'b0);
      check_bit("t2_stall", stall_o, 1'b0);

      // 1-cycle glitch is filtered out
      for (int j = 0; j < 10; j++) begin
         sclk_i = (j != 0);
         step();
         check_bit("t3a_fall", fall_o, 1'b0);
         check_bit("t3a_rise", rise_o, 1'b0);
         check_bit("t3a_active", active_o, 1'b0);
      end

      // 2-cycle glitch passes and is flagged too fast
      for (int j = 0; j < 24; j++) begin
         sclk_i = (j >= 2);
         step();
         check_bit("t3b_fall", fall_o, (j == 4));
         check_bit("t3b_rise", rise_o, (j == 6));
         check_bit("t3b_active", active_o, (j >= 4 && j < 22));
         check_bit("t3b_too_fast", too_fast_o, (j >= 6));
         if (j == 6) check_byte("t3b_half", half_period_o, 8'd2);
      end

      // Held low: stall, then release back to idle
      for (int j = 0; j < 40; j++) begin
         sclk_i = (j >= 30);
         step();
         check_bit("t4_fall", fall_o, (j == 4));
         check_bit("t4_rise", rise_o, (j == 34));
         check_bit("t4_active", active_o, (j >= 4 && j < 20));
         check_bit("t4_stall", stall_o, (j >= 20));
         check_bit("t4_too_fast", too_fast_o, 1'b1);
         if (j == 36) check_byte("t4_half", half_period_o, 8'd2);
      end

      // Clear alone, then clear coincident with a too-fast measurement
      clear_i = 1'b1;
      step();
      clear_i = 1'b0;
      check_bit("t5_clear_too_fast", too_fast_o, 1'b0);
      check_bit("t5_clear_stall", stall_o, 1'b0);
      for (int j = 0; j < 12; j++) begin
         sclk_i  = (j >= 2);
         clear_i = (j == 6);
         step();
         check_bit("t5_fall", fall_o, (j == 4));
         check_bit("t5_rise", rise_o, (j == 6));
         check_bit("t5_active", active_o, (j >= 4));
         check_bit("t5_set_vs_clear", too_fast_o, (j >= 6));
         check_bit("t5_stall", stall_o, 1'b0);
         if (j == 6) check_byte("t5_half", half_period_o, 8'd2);
      end
      clear_i = 1'b0;

      // Asynchronous reset mid-burst, released with the line low
      rst_ni = 1'b0;
      #1;
      check_all_zero("t6_async");
      sclk_i = 1'b0;
      step();
      step();
      check_all_zero("t6_held");
      rst_ni = 1'b1;
      for (int j = 0; j < 6; j++) begin
         step();
         check_bit("t6_fall", fall_o, (j == 4));
         check_bit("t6_rise", rise_o, 1'b0);
         check_bit("t6_active", active_o, (j >= 4));
      end
      check_byte("t6_half", half_period_o, 8'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
